// File: rtl/axism_pkg.sv
// Shared types for the AXI-Stream buffer source: FSM state encoding and enum.
package axism_pkg;

  localparam logic [1:0] ENC_IDLE   = 2'd0;
  localparam logic [1:0] ENC_FETCH  = 2'd1;
  localparam logic [1:0] ENC_STREAM = 2'd2;
  localparam logic [1:0] ENC_FINISH = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ENC_IDLE,
    S_FETCH  = ENC_FETCH,
    S_STREAM = ENC_STREAM,
    S_FINISH = ENC_FINISH
  } state_t;

endpackage

// File: rtl/axism_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (read-before-write).
module axism_sdp_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rd_data;

  // Both updates are non-blocking, so a colliding read returns the old word.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/axism_buffer_src.sv
// Streams WORDS entries of an internal buffer out as one AXI-Stream packet.
// Optional macro AXISM_BUFFER_SRC_LOOP_EN adds input LOOP for back-to-back repeated passes.
module axism_buffer_src
  import axism_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                WR_EN,
  input  logic [ADDR_W-1:0]   WR_ADDR,
  input  logic [DATA_W-1:0]   WR_DATA,
  input  logic                START,
  input  logic [ADDR_W:0]     WORDS,
`ifdef AXISM_BUFFER_SRC_LOOP_EN
  input  logic                LOOP,
`endif
  output logic                BUSY,
  output logic                DONE,
  output logic                AXIS_TCLK,
  output logic [DATA_W-1:0]   AXIS_TDATA,
  output logic [DATA_W/8-1:0] AXIS_TKEEP,
  output logic [DATA_W/8-1:0] AXIS_TSTRB,
  output logic                AXIS_TLAST,
  output logic                AXIS_TVALID,
  input  logic                AXIS_TREADY,
  output state_t              DBG_STATE
);

  localparam int              KEEP_W = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH  = {1'b1, {ADDR_W{1'b0}}};

  state_t              r_state, w_state_nxt;
  logic [ADDR_W:0]     r_words, r_beat;
  logic [DATA_W-1:0]   r_tdata;
  logic                r_tvalid, r_tlast, r_done;
  logic [ADDR_W:0]     w_words_clamp, w_rd_idx, w_load_idx;
  logic [DATA_W-1:0]   w_rd_data;
  logic                w_hs, w_loop, w_latch, w_load, w_clear;

  // Index following b in a packet of n words; wraps to 0 after the last beat.
  function automatic logic [ADDR_W:0] f_nxt(input logic [ADDR_W:0] b, input logic [ADDR_W:0] n);
    logic [ADDR_W:0] inc;
    inc = b + 1'b1;
    return (inc == n) ? '0 : inc;
  endfunction

`ifdef AXISM_BUFFER_SRC_LOOP_EN
  assign w_loop = LOOP;
`else
  assign w_loop = 1'b0;
`endif

  assign w_words_clamp = (WORDS > DEPTH) ? DEPTH : WORDS;

  // Valid/ready: a beat transfers on any edge where TVALID && TREADY; while TVALID
  // is high and TREADY low the beat registers hold, and TVALID only drops after
  // the final transfer of a packet.
  assign w_hs = r_tvalid & AXIS_TREADY;

  axism_sdp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .i_clk     (CLK),
    .i_wr_en   (WR_EN),
    .i_wr_addr (WR_ADDR),
    .i_wr_data (WR_DATA),
    .i_rd_addr (w_rd_idx[ADDR_W-1:0]),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // The RAM output always holds the word for the next beat, so a handshake can
  // load it immediately and the read address advances one beat ahead.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_idx    = '0;
    w_latch     = 1'b0;
    w_load      = 1'b0;
    w_load_idx  = '0;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_latch     = 1'b1;
          w_state_nxt = (w_words_clamp != '0) ? S_FETCH : S_FINISH;
        end
      end
      S_FETCH: begin
        w_state_nxt = S_STREAM;
        w_load      = 1'b1;
        w_rd_idx    = f_nxt('0, r_words);
      end
      S_STREAM: begin
        w_rd_idx = f_nxt(r_beat, r_words);
        if (w_hs) begin
          if (r_tlast && !w_loop) begin
            w_state_nxt = S_FINISH;
            w_clear     = 1'b1;
          end else begin
            w_load     = 1'b1;
            w_load_idx = f_nxt(r_beat, r_words);
            w_rd_idx   = f_nxt(w_load_idx, r_words);
          end
        end
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_words  <= '0;
      r_beat   <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if (w_latch) r_words <= w_words_clamp;
      if (w_load) begin
        r_tdata  <= w_rd_data;
        r_beat   <= w_load_idx;
        r_tvalid <= 1'b1;
        r_tlast  <= (f_nxt(w_load_idx, r_words) == '0);
      end else if (w_clear) begin
        r_tdata  <= '0;
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end
      r_done <= (r_state == S_FINISH);
    end
  end

  assign BUSY        = (r_state != S_IDLE);
  assign DONE        = r_done;
  assign AXIS_TCLK   = CLK;
  assign AXIS_TDATA  = r_tdata;
  assign AXIS_TLAST  = r_tlast;
  assign AXIS_TVALID = r_tvalid;
  assign AXIS_TKEEP  = {KEEP_W{r_tvalid}};
  assign AXIS_TSTRB  = {KEEP_W{r_tvalid}};
  assign DBG_STATE   = r_state;

endmodule

// File: tb/tb_axism_buffer_src.sv
// Scoreboard bench for axism_buffer_src: directed streams, stalls, reset abort, clamp.
module tb_axism_buffer_src;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2**ADDR_W;

  logic              clk, rst_n, wr_en, start, tready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W:0]   words;
  logic              busy, done, tclk, tlast, tvalid;
  logic [DATA_W-1:0] tdata;
  logic [3:0]        tkeep, tstrb;
  axism_pkg::state_t dbg_state;
`ifdef AXISM_BUFFER_SRC_LOOP_EN
  logic              loop_i;
`endif

  axism_buffer_src #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLK(clk), .RST_N(rst_n), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .START(start), .WORDS(words),
`ifdef AXISM_BUFFER_SRC_LOOP_EN
    .LOOP(loop_i),
`endif
    .BUSY(busy), .DONE(done), .AXIS_TCLK(tclk), .AXIS_TDATA(tdata), .AXIS_TKEEP(tkeep),
    .AXIS_TSTRB(tstrb), .AXIS_TLAST(tlast), .AXIS_TVALID(tvalid), .AXIS_TREADY(tready),
    .DBG_STATE(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  logic [DATA_W:0]   exp_q[$];
  logic [DATA_W-1:0] mem_m [DEPTH];
  int n_checks = 0, n_fail = 0;
  int beats_seen = 0, tlast_cnt = 0, done_cnt = 0, tvalid_seen = 0;
  int first_cyc = 0, last_cyc = 0, start_cyc = 0, done_cyc = 0;
  logic            prev_stall = 1'b0;
  logic [DATA_W:0] prev_word  = '0;
  logic [3:0]      pat = 4'b1001;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected queue on every handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (tvalid) begin
        tvalid_seen++;
        if (prev_stall) check("stall_stable", {tlast, tdata}, prev_word);
        if (tready) begin
          check("keep_strb", {tkeep, tstrb}, 8'hFF);
          if (exp_q.size() == 0) check("unexpected_beat", {tlast, tdata}, '1);
          else check("beat", {tlast, tdata}, exp_q.pop_front());
          if (beats_seen == 0) first_cyc = cyc;
          last_cyc = cyc;
          beats_seen++;
          if (tlast) tlast_cnt++;
        end
      end else begin
        if (prev_stall) check("valid_dropped", 1'b0, 1'b1);
        check("keep_idle", {tkeep, tstrb}, 8'h00);
      end
      prev_stall = tvalid && !tready;
      prev_word  = {tlast, tdata};
      if (done) done_cnt++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Driver tasks
  task automatic write_word(input int a, input logic [DATA_W-1:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = a[ADDR_W-1:0]; wr_data = d;
    mem_m[a] = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic push_exp(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), mem_m[i]});
  endtask

  task automatic clear_stats();
    beats_seen = 0; tlast_cnt = 0; done_cnt = 0; tvalid_seen = 0;
  endtask

  task automatic start_stream(input int w);
    @(posedge clk); #1;
    start = 1'b1; words = w[ADDR_W:0]; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit toggle);
    bit got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; done_cyc = cyc; end
      if (!got) begin
        @(posedge clk); #1;
        if (toggle) tready = pat[k % 4];
      end
    end
    if (!got) check("done_timeout", 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    tready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; words = '0; tready = 1'b1;
`ifdef AXISM_BUFFER_SRC_LOOP_EN
    loop_i = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_tlast", tlast, 1'b0);
    check("rst_tkeep_tstrb", {tkeep, tstrb}, 8'h00);
    check("rst_tdata", tdata, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) write_word(i, 32'hA000_0000 + i);

    // 8 words, TREADY held high
    clear_stats(); push_exp(8);
    start_stream(8);
    check("busy_after_start", busy, 1'b1);
    wait_done(40, 1'b0);
    check("t1_valid_latency", first_cyc - start_cyc, 2);
    check("t1_back_to_back", last_cyc - first_cyc, 7);
    check("t1_done_latency", done_cyc - last_cyc, 2);
    check("t1_beats", beats_seen, 8);
    check("t1_tlasts", tlast_cnt, 1);
    check("t1_dones", done_cnt, 1);
    check("t1_busy_end", busy, 1'b0);

    // 5 words with stalls 1,0,0,1
    clear_stats(); push_exp(5);
    start_stream(5);
    wait_done(60, 1'b1);
    check("t2_beats", beats_seen, 5);
    check("t2_tlasts", tlast_cnt, 1);
    check("t2_queue_empty", exp_q.size(), 0);

    // Zero-length request
    clear_stats();
    start_stream(0);
    wait_done(10, 1'b0);
    check("t3_done_latency", done_cyc - start_cyc, 2);
    check("t3_no_valid", tvalid_seen, 0);
    check("t3_dones", done_cnt, 1);
    check("t3_busy_end", busy, 1'b0);

    // START while busy is ignored
    clear_stats(); push_exp(4);
    start_stream(4);
    start_stream(3);
    wait_done(40, 1'b0);
    repeat (6) @(negedge clk);
    check("t4_beats", beats_seen, 4);
    check("t4_tlasts", tlast_cnt, 1);
    check("t4_dones", done_cnt, 1);

    // Reset while beat 3 of 8 is presented
    clear_stats(); push_exp(8);
    start_stream(8);
    for (int k = 0; k < 30 && beats_seen < 3; k++) @(negedge clk);
    check("t5_reached_beat3", beats_seen, 3);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("t5_tvalid", tvalid, 1'b0);
    check("t5_tlast", tlast, 1'b0);
    check("t5_tdata", tdata, 32'h0);
    check("t5_keep_strb", {tkeep, tstrb}, 8'h00);
    check("t5_busy", busy, 1'b0);
    check("t5_done", done, 1'b0);
    check("t5_state", dbg_state, axism_pkg::S_IDLE);
    check("t5_no_tlast", tlast_cnt, 0);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    clear_stats(); push_exp(2);
    start_stream(2);
    wait_done(20, 1'b0);
    check("t5_post_beats", beats_seen, 2);

    // Full buffer and clamp of an oversized count
    clear_stats(); push_exp(DEPTH);
    start_stream(DEPTH);
    wait_done(60, 1'b0);
    check("t6_full_beats", beats_seen, DEPTH);
    clear_stats(); push_exp(DEPTH);
    start_stream(DEPTH + 4);
    wait_done(60, 1'b0);
    check("t7_clamp_beats", beats_seen, DEPTH);
    check("t7_tlasts", tlast_cnt, 1);

    // Single-word packet under stalls, then rewritten contents
    clear_stats(); push_exp(1);
    start_stream(1);
    wait_done(20, 1'b1);
    check("t8_beats", beats_seen, 1);
    write_word(0, 32'h1234_5678);
    write_word(1, 32'hDEAD_BEEF);
    write_word(2, 32'h0000_00FF);
    clear_stats(); push_exp(3);
    start_stream(3);
    wait_done(30, 1'b1);
    check("t9_beats", beats_seen, 3);
    check("t9_queue_empty", exp_q.size(), 0);

`ifdef AXISM_BUFFER_SRC_LOOP_EN
    // Looping: three passes of 3 words with no bubbles
    clear_stats();
    push_exp(3); push_exp(3); push_exp(3);
    loop_i = 1'b1;
    start_stream(3);
    for (int k = 0; k < 30 && tlast_cnt < 2; k++) @(negedge clk);
    @(posedge clk); #1 loop_i = 1'b0;
    wait_done(30, 1'b0);
    check("loop_beats", beats_seen, 9);
    check("loop_back_to_back", last_cyc - first_cyc, 8);
    check("loop_tlasts", tlast_cnt, 3);
    check("loop_dones", done_cnt, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axism_buffer_src.md
AXISM_BUFFER_SRC -- requirements
Module: axism_buffer_src

Interface
REQ-001 SHALL have parameter DATA_W, default 32: TDATA width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 10: buffer depth is 2**ADDR_W words.
REQ-003 SHALL have port CLK  in  1  the single clock.
REQ-004 SHALL have port RST_N  in  1  asynchronous active-low reset.
REQ-005 SHALL have port WR_EN  in  1  buffer write strobe.
REQ-006 SHALL have port WR_ADDR  in  ADDR_W  buffer write address.
REQ-007 SHALL have port WR_DATA  in  DATA_W  buffer write data.
REQ-008 SHALL have port START  in  1  one-cycle stream request.
REQ-009 SHALL have port WORDS  in  ADDR_W+1  word count, sampled with START.
REQ-010 SHALL have port BUSY  out  1  high from accepted START to final handshake.
REQ-011 SHALL have port DONE  out  1  one-cycle pulse at stream completion.
REQ-012 SHALL have port AXIS_TCLK  out  1  equal to CLK.
REQ-013 SHALL have ports AXIS_TDATA out DATA_W, AXIS_TKEEP out DATA_W/8, AXIS_TSTRB out DATA_W/8, AXIS_TLAST out 1, AXIS_TVALID out 1, AXIS_TREADY in 1.

Function
REQ-014 SHALL write WR_DATA to buffer[WR_ADDR] on CLK when WR_EN, in any state.
REQ-015 SHALL read the buffer synchronously with 1-cycle latency; a same-cycle read and write to one address SHALL return the old data.
REQ-016 SHALL implement states IDLE, FETCH, STREAM, FINISH.
REQ-017 IDLE: START with WORDS>0 -> FETCH, latch WORDS, read address 0, BUSY=1.
REQ-018 IDLE: START with WORDS==0 -> FINISH; no beat is emitted.
REQ-019 FETCH -> STREAM after one cycle; TVALID rises 2 cycles after START.
REQ-020 Handshake occurs when TVALID && TREADY; TDATA, TLAST, TKEEP and TSTRB SHALL remain stable while TVALID && !TREADY.
REQ-021 TVALID SHALL NOT deassert inside a stream until the final handshake.
REQ-022 SHALL sustain one beat per cycle while TREADY is held high (prefetch of the next word at each handshake).
REQ-023 Beat i SHALL carry buffer[i], i = 0..WORDS-1; TLAST=1 only on beat WORDS-1.
REQ-024 TKEEP and TSTRB SHALL be all-ones while TVALID, zero otherwise.
REQ-025 STREAM: final handshake -> FINISH with TVALID=0 next cycle; FINISH -> IDLE after one cycle with DONE=1, BUSY=0.
REQ-026 START SHALL be ignored while BUSY.
REQ-027 WORDS = 2**ADDR_W SHALL stream the whole buffer; larger values SHALL be clamped to 2**ADDR_W.

Reset
REQ-028 RST_N low SHALL asynchronously force IDLE with BUSY, DONE, TVALID, TLAST, TKEEP, TSTRB and TDATA at 0.
REQ-029 Reset mid-stream SHALL abort with no TLAST; buffer contents are not cleared.

Configuration
REQ-030 With AXISM_BUFFER_SRC_LOOP_EN defined, SHALL add input LOOP; if LOOP is high at the final handshake, streaming SHALL restart at beat 0 with no bubble cycle, without DONE pulse, and TLAST on every pass's last beat.
REQ-031 Without AXISM_BUFFER_SRC_LOOP_EN, port LOOP SHALL be absent and every stream is single-pass.

Structure
REQ-032 Package axism_pkg SHALL hold the state enum and state encoding constants.
REQ-033 The buffer SHALL be sub-module axism_sdp_ram (simple dual-port, 1 write, 1 synchronous read).

Verification
REQ-034 Fill buffer[i]=32'hA000_0000+i, START WORDS=8, TREADY=1 -> 8 consecutive beats A0000000..A0000007, TLAST on beat 7, DONE 2 cycles after last beat.
REQ-035 Same fill, WORDS=5, TREADY toggled 1,0,0,1,... -> data held stable during stalls, exactly 5 beats, order intact.
REQ-036 START WORDS=0 -> no TVALID, DONE pulses, BUSY back to 0.
REQ-037 Second START during stream -> ignored, single TLAST, single DONE.
REQ-038 RST_N low on beat 3 of 8 -> all outputs 0 at once; new START WORDS=2 after reset -> buffer[0], buffer[1] streamed.
REQ-039 LOOP_EN build, LOOP=1, WORDS=3 for two passes then LOOP=0 -> beats 0,1,2,0,1,2,0,1,2 back-to-back, three TLASTs, one DONE.
